multiplier: RTL and testbench

MULTIPLIER -- requirements
Module: multiplier

---
 rtl/multiplier_pkg.sv | 44 ++++
 rtl/hex_driver.sv | 31 +++
 rtl/multiplier.sv | 122 ++++++++++++
 tb/tb_multiplier.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multiplier_pkg.sv
// Shared types and constants for the 8x8 signed shift-add multiplier.
// Holds the control FSM encoding and small state-decode helpers.
package multiplier_pkg;

    localparam int WIDTH = 8;

    typedef enum logic [4:0] {
        IDLE,
        START,
        ADD0,
        SHIFT0,
        ADD1,
        SHIFT1,
        ADD2,
        SHIFT2,
        ADD3,
        SHIFT3,
        ADD4,
        SHIFT4,
        ADD5,
        SHIFT5,
        ADD6,
        SHIFT6,
        ADD7,
        SHIFT7,
        DONE
    } state_t;

    // Partial-product accumulate steps for the non-sign multiplier bits.
    function automatic logic is_add(state_t s);
        return s inside {ADD0, ADD1, ADD2, ADD3, ADD4, ADD5, ADD6};
    endfunction

    // The sign bit of B carries negative weight, so its step subtracts.
    function automatic logic is_sub(state_t s);
        return s == ADD7;
    endfunction

    function automatic logic is_shift(state_t s);
        return s inside {SHIFT0, SHIFT1, SHIFT2, SHIFT3,
                         SHIFT4, SHIFT5, SHIFT6, SHIFT7};
    endfunction

endpackage

// File: rtl/hex_driver.sv
// Nibble to active-low 7-segment code.
// Bit order is g..a in [6:0]; a 0 lights the segment.
module hex_driver (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'b1111111;
        unique case (i_nibble)
            4'h0: o_seg = 7'b1000000;
            4'h1: o_seg = 7'b1111001;
            4'h2: o_seg = 7'b0100100;
            4'h3: o_seg = 7'b0110000;
            4'h4: o_seg = 7'b0011001;
            4'h5: o_seg = 7'b0010010;
            4'h6: o_seg = 7'b0000010;
            4'h7: o_seg = 7'b1111000;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0010000;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b0000011;
            4'hC: o_seg = 7'b1000110;
            4'hD: o_seg = 7'b0100001;
            4'hE: o_seg = 7'b0000110;
            4'hF: o_seg = 7'b0001110;
            default: o_seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/multiplier.sv
// Signed 8x8 sequential multiplier: X:A:B shift-add datapath,
// control FSM and four 7-segment displays for A and B.
module multiplier
    import multiplier_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             X,
    output logic [6:0]       AhexU,
    output logic [6:0]       AhexL,
    output logic [6:0]       BhexU,
    output logic [6:0]       BhexL
);

    state_t           r_state;
    state_t           w_state_n;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_x;
    logic [WIDTH-1:0] w_a_n;
    logic [WIDTH-1:0] w_b_n;
    logic             w_x_n;

    logic             w_load;
    logic             w_clear;
    logic             w_accum;
    logic             w_sub;
    logic             w_shift;
    logic [WIDTH:0]   w_addend;
    logic [WIDTH:0]   w_sum;

    assign w_load  = (r_state == IDLE) && Run && !ClearA_LoadB;
    assign w_clear = (r_state == START);
    assign w_sub   = is_sub(r_state);
    assign w_accum = (is_add(r_state) || w_sub) && r_b[0];
    assign w_shift = is_shift(r_state);

    // 9-bit add/subtract on sign-extended operands; subtract is ~S + 1.
    assign w_addend = w_sub ? ~{S[WIDTH-1], S} : {S[WIDTH-1], S};
    assign w_sum    = {r_a[WIDTH-1], r_a} + w_addend
                    + {{WIDTH{1'b0}}, w_sub};

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            IDLE:    if (!Run) w_state_n = START;
            START:   w_state_n = ADD0;
            ADD0:    w_state_n = SHIFT0;
            SHIFT0:  w_state_n = ADD1;
            ADD1:    w_state_n = SHIFT1;
            SHIFT1:  w_state_n = ADD2;
            ADD2:    w_state_n = SHIFT2;
            SHIFT2:  w_state_n = ADD3;
            ADD3:    w_state_n = SHIFT3;
            SHIFT3:  w_state_n = ADD4;
            ADD4:    w_state_n = SHIFT4;
            SHIFT4:  w_state_n = ADD5;
            ADD5:    w_state_n = SHIFT5;
            SHIFT5:  w_state_n = ADD6;
            ADD6:    w_state_n = SHIFT6;
            SHIFT6:  w_state_n = ADD7;
            ADD7:    w_state_n = SHIFT7;
            SHIFT7:  w_state_n = DONE;
            DONE:    if (Run) w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    always_comb begin
        w_a_n = r_a;
        w_b_n = r_b;
        w_x_n = r_x;
        unique case (1'b1)
            w_load: begin
                w_a_n = '0;
                w_x_n = 1'b0;
                w_b_n = S;
            end
            w_clear: begin
                w_a_n = '0;
                w_x_n = 1'b0;
            end
            w_accum: begin
                {w_x_n, w_a_n} = w_sum;
            end
            w_shift: begin
                w_a_n = {r_x, r_a[WIDTH-1:1]};
                w_b_n = {r_a[0], r_b[WIDTH-1:1]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_x     <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_a     <= w_a_n;
            r_b     <= w_b_n;
            r_x     <= w_x_n;
        end
    end

    assign Aval = r_a;
    assign Bval = r_b;
    assign X    = r_x;

    hex_driver u_hex_au (.i_nibble(r_a[7:4]), .o_seg(AhexU));
    hex_driver u_hex_al (.i_nibble(r_a[3:0]), .o_seg(AhexL));
    hex_driver u_hex_bu (.i_nibble(r_b[7:4]), .o_seg(BhexU));
    hex_driver u_hex_bl (.i_nibble(r_b[3:0]), .o_seg(BhexL));

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for the sequential signed multiplier.
// Expected products come from plain signed integer arithmetic.
module tb_multiplier;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Run;
    logic       ClearA_LoadB;
    logic [7:0] S;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       X;
    logic [6:0] AhexU;
    logic [6:0] AhexL;
    logic [6:0] BhexU;
    logic [6:0] BhexL;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] seg_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    multiplier dut (
        .Clk(Clk),
        .Reset(Reset),
        .Run(Run),
        .ClearA_LoadB(ClearA_LoadB),
        .S(S),
        .Aval(Aval),
        .Bval(Bval),
        .X(X),
        .AhexU(AhexU),
        .AhexL(AhexL),
        .BhexU(BhexU),
        .BhexL(BhexL)
    );

    always #5 Clk = ~Clk;

    // Reference: {sign, 16-bit product} of two signed bytes.
    function automatic logic [16:0] ref_mul(logic [7:0] b, logic [7:0] s);
        int signed p;
        logic [31:0] t;
        p = int'($signed(b)) * int'($signed(s));
        t = p;
        return {t[15], t[15:0]};
    endfunction

    task automatic tick(int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic do_load(logic [7:0] v);
        S = v;
        ClearA_LoadB = 1'b0;
        tick(1);
        ClearA_LoadB = 1'b1;
        tick(1);
    endtask

    task automatic do_run(logic [7:0] s, int cycles);
        S = s;
        Run = 1'b0;
        tick(cycles);
    endtask

    task automatic do_release();
        ClearA_LoadB = 1'b1;
        Run = 1'b1;
        tick(2);
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        Run = 1'b1;
        ClearA_LoadB = 1'b1;
        S = 8'h00;
        tick(2);
        n_cmp++;
        if ({X, Aval, Bval} !== 17'h0) begin
            n_bad++;
            $display("FAIL reset_regs got %h want 00000", {X, Aval, Bval});
        end
        n_cmp++;
        if ({AhexU, AhexL, BhexU, BhexL} !== {4{seg_tbl[0]}}) begin
            n_bad++;
            $display("FAIL reset_hex got %h %h %h %h want 40 each",
                     AhexU, AhexL, BhexU, BhexL);
        end
        Reset = 1'b1;
        tick(1);
    endtask

    task automatic test_load_then_run();
        logic [16:0] exp;
        S = 8'hC5;
        ClearA_LoadB = 1'b0;
        tick(1);
        n_cmp++;
        if (Bval !== 8'hC5 || Aval !== 8'h00) begin
            n_bad++;
            $display("FAIL load_b got A=%h B=%h want A=00 B=c5", Aval, Bval);
        end
        ClearA_LoadB = 1'b1;
        tick(1);
        exp = ref_mul(8'hC5, 8'h07);
        do_run(8'h07, 22);
        n_cmp++;
        if ({X, Aval, Bval} !== exp) begin
            n_bad++;
            $display("FAIL c5x07 got %h want %h", {X, Aval, Bval}, exp);
        end
        do_release();
    endtask

    task automatic test_operand_order();
        logic [16:0] exp;
        do_load(8'h07);
        exp = ref_mul(8'h07, 8'hC5);
        do_run(8'hC5, 22);
        n_cmp++;
        if ({X, Aval, Bval} !== exp) begin
            n_bad++;
            $display("FAIL 07xc5 got %h want %h", {X, Aval, Bval}, exp);
        end
        do_release();
    endtask

    task automatic test_chained();
        logic [16:0] exp;
        logic [7:0]  lo;
        do_load(8'hFF);
        exp = ref_mul(8'hFF, 8'hFF);
        do_run(8'hFF, 22);
        n_cmp++;
        if ({X, Aval, Bval} !== exp) begin
            n_bad++;
            $display("FAIL ffxff got %h want %h", {X, Aval, Bval}, exp);
        end
        lo = exp[7:0];
        do_release();
        exp = ref_mul(lo, 8'hFF);
        do_run(8'hFF, 22);
        n_cmp++;
        if ({X, Aval, Bval} !== exp) begin
            n_bad++;
            $display("FAIL chained got %h want %h", {X, Aval, Bval}, exp);
        end
        do_release();
    endtask

    task automatic test_boundary();
        logic [7:0]  bv [3] = '{8'h80, 8'h80, 8'h00};
        logic [7:0]  sv [3] = '{8'h80, 8'h7F, 8'hA7};
        logic [16:0] exp;
        for (int i = 0; i < 3; i++) begin
            do_load(bv[i]);
            exp = ref_mul(bv[i], sv[i]);
            do_run(sv[i], 22);
            n_cmp++;
            if ({X, Aval, Bval} !== exp) begin
                n_bad++;
                $display("FAIL boundary_%0d got %h want %h",
                         i, {X, Aval, Bval}, exp);
            end
            do_release();
        end
    endtask

    task automatic test_latency();
        logic [16:0] exp;
        do_load(8'h5B);
        exp = ref_mul(8'h5B, 8'hE3);
        do_run(8'hE3, 18);
        n_cmp++;
        if ({X, Aval, Bval} !== exp) begin
            n_bad++;
            $display("FAIL latency18 got %h want %h", {X, Aval, Bval}, exp);
        end
        do_release();
    endtask

    task automatic test_hold_done();
        logic [16:0] exp;
        int          bad_cyc;
        do_load(8'h3C);
        exp = ref_mul(8'h3C, 8'hD9);
        do_run(8'hD9, 20);
        bad_cyc = 0;
        for (int i = 0; i < 25; i++) begin
            if (i == 10) begin
                S = 8'h11;
                ClearA_LoadB = 1'b0;
            end
            tick(1);
            if ({X, Aval, Bval} !== exp) bad_cyc++;
        end
        n_cmp++;
        if (bad_cyc != 0) begin
            n_bad++;
            $display("FAIL done_hold got %0d changed cycles want 0, last %h exp %h",
                     bad_cyc, {X, Aval, Bval}, exp);
        end
        do_release();
        do_load(8'h2A);
        n_cmp++;
        if (Bval !== 8'h2A || Aval !== 8'h00 || X !== 1'b0) begin
            n_bad++;
            $display("FAIL reload_after_done got A=%h B=%h X=%b want 00 2a 0",
                     Aval, Bval, X);
        end
    endtask

    task automatic test_midrun_reset();
        logic [16:0] exp;
        do_load(8'h77);
        do_run(8'h99, 9);
        Reset = 1'b0;
        #1;
        n_cmp++;
        if ({X, Aval, Bval} !== 17'h0) begin
            n_bad++;
            $display("FAIL midrun_reset got %h want 00000", {X, Aval, Bval});
        end
        Run = 1'b1;
        tick(1);
        Reset = 1'b1;
        tick(3);
        n_cmp++;
        if ({X, Aval, Bval} !== 17'h0 || AhexU !== seg_tbl[0]) begin
            n_bad++;
            $display("FAIL post_reset_idle got %h hex %h want 00000 40",
                     {X, Aval, Bval}, AhexU);
        end
        do_load(8'h03);
        exp = ref_mul(8'h03, 8'h05);
        do_run(8'h05, 22);
        n_cmp++;
        if ({X, Aval, Bval} !== exp) begin
            n_bad++;
            $display("FAIL run_after_reset got %h want %h", {X, Aval, Bval}, exp);
        end
        do_release();
    endtask

    task automatic test_hex();
        logic [7:0] v;
        int         bad_hex;
        bad_hex = 0;
        for (int n = 0; n < 16; n++) begin
            v = {4'(n), 4'(15 - n)};
            do_load(v);
            if (BhexU !== seg_tbl[n] || BhexL !== seg_tbl[15 - n]) begin
                bad_hex++;
                $display("FAIL hex_b_%0d got %b %b want %b %b", n, BhexU,
                         BhexL, seg_tbl[n], seg_tbl[15 - n]);
            end
        end
        n_cmp++;
        if (bad_hex != 0) n_bad++;
    endtask

    task automatic test_random();
        logic [7:0]  b;
        logic [7:0]  s;
        logic [16:0] exp;
        int          bad_r;
        int          bad_h;
        bad_r = 0;
        bad_h = 0;
        b = 8'($urandom);
        do_load(b);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                b = 8'($urandom);
                do_load(b);
            end else begin
                b = Bval;
            end
            s = 8'($urandom);
            exp = ref_mul(b, s);
            S = s;
            Run = 1'b0;
            tick(1);
            ClearA_LoadB = 1'($urandom);
            tick(21);
            if ({X, Aval, Bval} !== exp) begin
                bad_r++;
                $display("FAIL rand_%0d %h*%h got %h want %h",
                         i, b, s, {X, Aval, Bval}, exp);
            end
            if (AhexU !== seg_tbl[exp[15:12]] ||
                AhexL !== seg_tbl[exp[11:8]]) begin
                bad_h++;
                $display("FAIL rand_hex_%0d got %b %b for A=%h",
                         i, AhexU, AhexL, exp[15:8]);
            end
            do_release();
        end
        n_cmp++;
        if (bad_r != 0) n_bad++;
        n_cmp++;
        if (bad_h != 0) n_bad++;
    endtask

    initial begin
        test_reset();
        test_load_then_run();
        test_operand_order();
        test_chained();
        test_boundary();
        test_latency();
        test_hold_done();
        test_midrun_reset();
        test_hex();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
